// File: rtl/effect_noise_gate_if.sv
// effect_noise_gate_if
// Bundles the sample-stream signals of the noise gate. Clock and reset are
// plain ports on the gate itself.
//   i_valid     - one-cycle pulse per audio sample from the previous stage
//   i_enable    - 1 = gate active, 0 = bypass
//   i_level     - open threshold select (0..7)
//   i_data      - signed input sample
//   o_data      - signed gated output sample
//   o_valid     - i_valid delayed by one cycle
//   o_gate_open - gate is not fully closed
// master: the stage feeding the gate. slave: the gate.
interface effect_noise_gate_if;
    logic               i_valid;
    logic               i_enable;
    logic [2:0]         i_level;
    logic signed [15:0] i_data;
    logic signed [15:0] o_data;
    logic               o_valid;
    logic               o_gate_open;

    modport master (
        output i_valid, i_enable, i_level, i_data,
        input  o_data, o_valid, o_gate_open
    );

    modport slave (
        input  i_valid, i_enable, i_level, i_data,
        output o_data, o_valid, o_gate_open
    );
endinterface

// File: rtl/effect_noise_gate.sv
// effect_noise_gate
// Sample-rate noise gate (downward expander). An envelope follower feeds a
// gain state machine. The gain (0..256, 256 = unity) scales each sample. The
// block adds one register stage of latency.
//
// Ports:
//   i_clk   - clock, rising edge
//   i_rst_n - asynchronous active-low reset
//   bus     - effect_noise_gate_if.slave (i_valid, i_enable, i_level, i_data,
//             o_data, o_valid, o_gate_open)
//
// Build option: EFFECT_NOISE_GATE_HOLD_EN
//   When it is defined, the gate keeps full gain for HOLD_SAMPLES samples after
//   the envelope drops, and only then releases.
//   When it is not defined, OPEN goes straight to RELEASE.
//
// state   | meaning
// --------+-------------------------------------------------------------
// CLOSED  | gain 0; waiting for env to reach the open threshold
// ATTACK  | gain ramping up by ATTACK_STEP per sample toward unity
// OPEN    | unity gain; watching for env to fall below thr/2
// HOLD    | unity gain; counting down hold_cnt before releasing
// RELEASE | gain ramping down by RELEASE_STEP; re-attacks if env reopens
module effect_noise_gate #(
    parameter int unsigned HOLD_SAMPLES    = 2400,
    parameter int unsigned ATTACK_STEP     = 32,
    parameter int unsigned RELEASE_STEP    = 1,
    parameter int unsigned ENV_DECAY_SHIFT = 6
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    effect_noise_gate_if.slave  bus
);

`ifdef EFFECT_NOISE_GATE_HOLD_EN
    typedef enum logic [2:0] {
        ST_CLOSED,
        ST_ATTACK,
        ST_OPEN,
        ST_HOLD,
        ST_RELEASE
    } state_t;

    localparam int unsigned HOLD_W = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;

    logic [HOLD_W-1:0] hold_q, hold_d;
`else
    typedef enum logic [2:0] {
        ST_CLOSED,
        ST_ATTACK,
        ST_OPEN,
        ST_RELEASE
    } state_t;
`endif

    state_t             state_q, state_d;
    logic [15:0]        env_q, env_d;
    logic [8:0]         gain_q, gain_d;
    logic signed [15:0] data_q, data_d;
    logic               valid_q;

    logic [15:0]        abs_val, thr, thr_close, env_decay, env_next;
    logic [9:0]         gain_up;
    logic [8:0]         gain_up_sat, gain_dn;
    logic               attack_done, release_done, open_hit, close_hit;
    logic signed [15:0] scaled;

    // Magnitude; -32768 has no positive twin, so it pins to 32767.
    always_comb begin
        abs_val = bus.i_data[15] ? 16'(-bus.i_data) : bus.i_data;
        if (bus.i_data == 16'sh8000) begin
            abs_val = 16'h7FFF;
        end
    end

    always_comb begin
        thr = 16'd8192;
        case (bus.i_level)
            3'd0:    thr = 16'd256;
            3'd1:    thr = 16'd512;
            3'd2:    thr = 16'd1024;
            3'd3:    thr = 16'd2048;
            3'd4:    thr = 16'd3072;
            3'd5:    thr = 16'd4096;
            3'd6:    thr = 16'd6144;
            default: thr = 16'd8192;
        endcase
    end

    // The close threshold is half the open threshold, which gives hysteresis.
    assign thr_close = {1'b0, thr[15:1]};
    assign env_decay = env_q - (env_q >> ENV_DECAY_SHIFT);
    assign env_next  = (abs_val > env_q) ? abs_val : env_decay;
    assign open_hit  = (env_next >= thr);
    assign close_hit = (env_next < thr_close);

    // Gain ramps saturate at the ends of 0..256. The 10-bit sum cannot wrap.
    assign gain_up      = {1'b0, gain_q} + 10'(ATTACK_STEP);
    assign attack_done  = (gain_up >= 10'd256);
    assign gain_up_sat  = attack_done ? 9'd256 : gain_up[8:0];
    assign release_done = ({1'b0, gain_q} <= 10'(RELEASE_STEP));
    assign gain_dn      = release_done ? 9'd0 : (gain_q - 9'(RELEASE_STEP));

    // Scale by the gain held before this sample. The arithmetic shift rounds
    // toward -inf, and |result| <= 32768 always fits in 16 bits.
    assign scaled = 16'(($signed({{10{bus.i_data[15]}}, bus.i_data})
                       * $signed({17'd0, gain_q})) >>> 8);

    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        gain_d  = gain_q;
        data_d  = data_q;
`ifdef EFFECT_NOISE_GATE_HOLD_EN
        hold_d  = hold_q;
`endif
        if (bus.i_valid) begin
            if (!bus.i_enable) begin
                data_d  = bus.i_data;
                state_d = ST_CLOSED;
                env_d   = '0;
                gain_d  = '0;
`ifdef EFFECT_NOISE_GATE_HOLD_EN
                hold_d  = '0;
`endif
            end else begin
                data_d = scaled;
                env_d  = env_next;
                case (state_q)
                    ST_CLOSED: begin
                        gain_d = '0;
                        // The first attack step lands on the triggering sample,
                        // so the next sample already hears gain.
                        if (open_hit) begin
                            gain_d  = gain_up_sat;
                            state_d = attack_done ? ST_OPEN : ST_ATTACK;
                        end
                    end
                    ST_ATTACK: begin
                        gain_d = gain_up_sat;
                        if (attack_done) begin
                            state_d = ST_OPEN;
                        end
                    end
                    ST_OPEN: begin
                        gain_d = 9'd256;
                        if (close_hit) begin
`ifdef EFFECT_NOISE_GATE_HOLD_EN
                            state_d = ST_HOLD;
                            hold_d  = HOLD_W'(HOLD_SAMPLES - 1);
`else
                            state_d = ST_RELEASE;
`endif
                        end
                    end
`ifdef EFFECT_NOISE_GATE_HOLD_EN
                    ST_HOLD: begin
                        gain_d = 9'd256;
                        if (open_hit) begin
                            state_d = ST_OPEN;
                        end else if (hold_q == '0) begin
                            state_d = ST_RELEASE;
                        end else begin
                            hold_d = hold_q - 1'b1;
                        end
                    end
`endif
                    ST_RELEASE: begin
                        // A re-trigger keeps the current gain so the ramp back
                        // up starts without a click.
                        if (open_hit) begin
                            state_d = ST_ATTACK;
                        end else begin
                            gain_d = gain_dn;
                            if (release_done) begin
                                state_d = ST_CLOSED;
                            end
                        end
                    end
                    default: begin
                        state_d = ST_CLOSED;
                        gain_d  = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_CLOSED;
            env_q   <= '0;
            gain_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
`ifdef EFFECT_NOISE_GATE_HOLD_EN
            hold_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            env_q   <= env_d;
            gain_q  <= gain_d;
            data_q  <= data_d;
            valid_q <= bus.i_valid;
`ifdef EFFECT_NOISE_GATE_HOLD_EN
            hold_q  <= hold_d;
`endif
        end
    end

    assign bus.o_data      = data_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_gate_open = (state_q != ST_CLOSED);

endmodule

// File: tb/tb_effect_noise_gate.sv
// tb_effect_noise_gate
// Directed bench for effect_noise_gate. The DUT is built with HOLD_SAMPLES=4,
// ATTACK_STEP=64, RELEASE_STEP=64 and ENV_DECAY_SHIFT=1. The fast decay lets the
// envelope fall within a few samples. The stimulus pushes hand-computed
// expected outputs into a queue. A monitor pops one entry on every o_valid and
// compares it with the DUT output.
module tb_effect_noise_gate;

    logic clk;
    logic rst_n;

    effect_noise_gate_if bus ();

    effect_noise_gate #(
        .HOLD_SAMPLES    (4),
        .ATTACK_STEP     (64),
        .RELEASE_STEP    (64),
        .ENV_DECAY_SHIFT (1)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The hold phase adds four unity-gain samples before the release starts.
`ifdef EFFECT_NOISE_GATE_HOLD_EN
    localparam int HOLD_EXTRA = 4;
`else
    localparam int HOLD_EXTRA = 0;
`endif

    typedef struct {
        logic [15:0] data;
        logic        gate;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [15:0] hold_val;
    int          n_checks;
    int          n_fail;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%04h) expected %0d (0x%04h) at %0t",
                     name, $signed(act), act, $signed(req), req, $time);
        end
    endtask

    // Monitor: on each o_valid, compare the output with the next queued
    // expectation. Between samples, o_data must hold its last value.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_val = 16'd0;
        end else if (bus.o_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_o_valid: got o_valid=1 expected no output at %0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("o_data", bus.o_data, mon_e.data);
                check("o_gate_open", {15'd0, bus.o_gate_open}, {15'd0, mon_e.gate});
                hold_val = mon_e.data;
            end
        end else begin
            check("o_data_hold", bus.o_data, hold_val);
        end
    end

    // Drive one valid sample, queue its expected response, then idle gap cycles.
    task automatic send(input logic en, input logic [15:0] din, input logic [15:0] dexp,
                        input logic gexp, input int gap);
        exp_t e;
        e.data = dexp;
        e.gate = gexp;
        exp_q.push_back(e);
        bus.i_enable = en;
        bus.i_data   = din;
        bus.i_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        for (int k = 0; k < gap; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        hold_val     = 16'd0;
        rst_n        = 1'b0;
        bus.i_valid  = 1'b0;
        bus.i_enable = 1'b0;
        bus.i_level  = 3'd3;
        bus.i_data   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_o_data", bus.o_data, 16'd0);
        check("reset_o_valid", {15'd0, bus.o_valid}, 16'd0);
        check("reset_o_gate_open", {15'd0, bus.o_gate_open}, 16'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Bypass passes the sample straight through.
        send(1'b0, 16'd1234, 16'd1234, 1'b0, 2);

        // Quiet input below the 2048 threshold stays closed.
        bus.i_level = 3'd3;
        for (int i = 0; i < 3; i++) send(1'b1, 16'd500, 16'd0, 1'b0, 1);

        // Step to 4000: 64-per-sample attack, issued back to back.
        send(1'b1, 16'd4000, 16'd0,    1'b1, 0);
        send(1'b1, 16'd4000, 16'd1000, 1'b1, 0);
        send(1'b1, 16'd4000, 16'd2000, 1'b1, 0);
        send(1'b1, 16'd4000, 16'd3000, 1'b1, 0);
        send(1'b1, 16'd4000, 16'd4000, 1'b1, 0);
        send(1'b1, 16'd4000, 16'd4000, 1'b1, 0);
        send(1'b1, 16'd4000, 16'd4000, 1'b1, 1);

        // Most negative input at unity gain.
        send(1'b1, 16'h8000, 16'h8000, 1'b1, 1);

        // Drop to 512: the envelope decays from 32767 and sits at thr_close
        // for one sample, then closes. Hold follows, then 192/128/64/0.
        for (int i = 0; i < 7 + HOLD_EXTRA; i++) send(1'b1, 16'd512, 16'd512, 1'b1, 0);
        send(1'b1, 16'd512, 16'd384, 1'b1, 0);
        send(1'b1, 16'd512, 16'd256, 1'b1, 0);
        send(1'b1, 16'd512, 16'd128, 1'b0, 0);
        send(1'b1, 16'd512, 16'd0,   1'b0, 0);
        send(1'b1, 16'd512, 16'd0,   1'b0, 1);

        // Open again, release to gain 128, then re-trigger.
        send(1'b1, 16'd4000, 16'd0,    1'b1, 0);
        send(1'b1, 16'd4000, 16'd1000, 1'b1, 0);
        send(1'b1, 16'd4000, 16'd2000, 1'b1, 0);
        send(1'b1, 16'd4000, 16'd3000, 1'b1, 0);
        send(1'b1, 16'd4000, 16'd4000, 1'b1, 1);
        for (int i = 0; i < 3 + HOLD_EXTRA; i++) send(1'b1, 16'd512, 16'd512, 1'b1, 0);
        send(1'b1, 16'd512,  16'd384,  1'b1, 0);
        send(1'b1, 16'd4000, 16'd2000, 1'b1, 0);
        send(1'b1, 16'd4000, 16'd2000, 1'b1, 0);
        send(1'b1, 16'd4000, 16'd3000, 1'b1, 0);
        send(1'b1, 16'd4000, 16'd4000, 1'b1, 1);

        // Bypass clears the gate, then a fresh attack. Reset lands mid-attack.
        send(1'b0, 16'd1234, 16'd1234, 1'b0, 1);
        send(1'b1, 16'd4000, 16'd0,    1'b1, 1);
        bus.i_enable = 1'b1;
        bus.i_data   = 16'd4000;
        bus.i_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        check("mid_attack_o_valid", {15'd0, bus.o_valid}, 16'd1);
        check("mid_attack_o_data", bus.o_data, 16'd1000);
        check("mid_attack_o_gate_open", {15'd0, bus.o_gate_open}, 16'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_o_data", bus.o_data, 16'd0);
        check("async_reset_o_valid", {15'd0, bus.o_valid}, 16'd0);
        check("async_reset_o_gate_open", {15'd0, bus.o_gate_open}, 16'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("expected_queue_drained", 16'(exp_q.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/effect_noise_gate.md
# effect_noise_gate

Sample-rate noise gate (downward expander) for the audio effects chain. It is the inverse dynamics stage to the chain's compressor: it attenuates quiet material instead of squashing loud material. It sits in the same i_valid/o_valid pulse pipeline, one register stage deep. An envelope follower drives an attack/open/hold/release gain state machine, and the gain scales each sample.

## Interface
- HOLD_SAMPLES, 2400: valid samples the gate stays open after the envelope drops (50 ms at 48 kHz); minimum 1.
- ATTACK_STEP, 32: gain increment per valid sample in ATTACK; 1..256.
- RELEASE_STEP, 1: gain decrement per valid sample in RELEASE; 1..256.
- ENV_DECAY_SHIFT, 6: envelope decay, env -= env >> ENV_DECAY_SHIFT per sample; 1..15.
- i_clk  in  1  clock; rising edge.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_valid  in  1  one-cycle sync pulse from the previous stage, one per audio sample.
- i_enable  in  1  1 = gate active; 0 = bypass.
- i_level  in  3  open threshold select: 0..7 → 256, 512, 1024, 2048, 3072, 4096, 6144, 8192.
- i_data  in  16  signed input sample.
- o_data  out  16  signed output sample; reset 0.
- o_valid  out  1  registered copy of i_valid; reset 0.
- o_gate_open  out  1  1 when the state is not CLOSED; reset 0.

## Operation
- Signal names:
  - abs = |i_data|, with -32768 saturated to 32767.
  - thr = threshold from i_level.
  - thr_close = thr >> 1, which gives the hysteresis.
- Envelope, 16-bit unsigned, reset 0, updates only on enabled valid samples:
  - env_next = abs if abs > env.
  - Otherwise env_next = env - (env >> ENV_DECAY_SHIFT).
  - All FSM decisions for a sample use env_next.
- Gain, 9-bit unsigned, range 0..256, reset 0. 256 is unity.
- Output: o_data = (i_data * signed{1'b0,gain}) >>> 8, using the gain value from before this sample's update.
  - The 25-bit product is shifted arithmetically, which truncates toward -inf.
  - The result always fits in 16 bits, so no saturation is needed.
- FSM states: CLOSED, ATTACK, OPEN, HOLD, RELEASE. Reset state is CLOSED. It advances only on valid samples while enabled.
- CLOSED: gain = 0. If env_next ≥ thr, go to ATTACK.
- ATTACK: gain = min(gain + ATTACK_STEP, 256). When the gain reaches 256, go to OPEN.
- OPEN: gain = 256. If env_next < thr_close, go to HOLD and load hold_cnt = HOLD_SAMPLES - 1.
- HOLD: gain = 256.
  - If env_next ≥ thr, go to OPEN.
  - Else if hold_cnt == 0, go to RELEASE.
  - Else decrement hold_cnt.
- RELEASE:
  - If env_next ≥ thr, go to ATTACK. The gain keeps its current value, so there is no click.
  - Otherwise gain = max(gain - RELEASE_STEP, 0). When the gain reaches 0, go to CLOSED.
- Bypass (i_enable = 0):
  - On valid, o_data <= i_data.
  - env, gain and hold_cnt clear to 0 and the state forces to CLOSED.
  - When re-enabled, the gate starts closed and fades in through ATTACK.
- i_level changes take effect on the next valid sample. No state is reset on a level change.

## Timing
- Latency is 1 cycle: o_valid and o_data update on the clock edge where i_valid = 1.
- o_valid = i_valid delayed by one cycle.
- o_data holds its value while i_valid = 0.
- Back-to-back valid pulses on every cycle are supported, at full throughput.
- Asynchronous reset mid-operation clears all outputs, env, gain and hold_cnt immediately, and the state returns to CLOSED.
- Threshold boundary: env_next == thr counts as open; env_next == thr_close counts as not closing.

## Configuration
- EFFECT_NOISE_GATE_HOLD_EN defined: the HOLD state and hold_cnt exist as described above.
- Not defined: the HOLD state is removed and OPEN goes directly to RELEASE when env_next < thr_close. HOLD_SAMPLES is ignored.

## Test plan
All scenarios use HOLD_SAMPLES=4, ATTACK_STEP=64, RELEASE_STEP=64 and EFFECT_NOISE_GATE_HOLD_EN defined.

- Reset, then i_enable=0 with i_data=1234 valid → o_data=1234 one cycle later, o_valid pulses once, o_gate_open=0.
- i_level=3 (thr 2048), enabled, constant i_data=500 → o_data=0 indefinitely, o_gate_open=0.
- Step to i_data=4000 → outputs 0, 1000, 2000, 3000, then 4000 steady; the state passes through ATTACK to OPEN.
- Input -32768 with the gate OPEN → o_data=-32768, abs saturates to 32767, no overflow.
- After OPEN, drop the input to 0 → 4 samples at full gain (HOLD), then release at gain 192, 128, 64, 0, then CLOSED. o_gate_open falls on the CLOSED edge.
- Re-trigger with 4000 during RELEASE at gain 128 → ATTACK resumes from 128 and reaches 256 after 2 samples. Separately, assert reset mid-ATTACK → o_data=0, o_valid=0 and o_gate_open=0 immediately.
